seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Iterative shift-subtract (restoring) integer divider for the ALU datapath. It is the inverse companion to the ALU's combinational add/sub/shift unit and supplies the DIV result that the ALU multiplexer selects. It takes one quotient bit per clock, uses a start/done handshake, and supports unsigned or signed (two's complement) operands.

Parameters:
WIDTH, 16, operand and result width in bits (must be >= 2)

Ports:
i_clk  input  1  system clock; all state updates on the rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  request pulse; sampled only in IDLE
i_signed  input  1  1'b0 unsigned, 1'b1 signed; captured together with the operands
i_dividend  input  WIDTH  dividend; captured on an accepted start
i_divisor  input  WIDTH  divisor; captured on an accepted start
o_quotient  output  WIDTH  quotient, registered
o_remainder  output  WIDTH  remainder, registered
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse; results are valid in this cycle
o_div_zero  output  1  divisor was zero; valid with o_done

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: state=IDLE. o_quotient, o_remainder, o_busy, o_done and o_div_zero are all 0. Internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If i_start=1, capture the operands and i_signed.
  - Divisor != 0: load the magnitude registers, clear the partial remainder, set the bit counter to WIDTH-1, go to CALC.
  - Divisor == 0: go straight to DONE.
- Operand magnitudes: in signed mode, negative operands are negated to magnitudes. Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
- CALC (exactly WIDTH cycles), each cycle:
  - Partial remainder R (WIDTH+1 bits) = {R, next dividend MSB}.
  - If R >= |divisor|: R -= |divisor| and the quotient bit is 1, else the quotient bit is 0.
  - The counter decrements. At counter==0, go to FIX.
- FIX (1 cycle):
  - Apply sign correction: quotient is negated if sign_q, remainder is negated if sign_r.
  - Signed division truncates toward zero. The remainder takes the sign of the dividend.
  - Write o_quotient and o_remainder. Go to DONE.
- Divide-by-zero: o_quotient = all ones, o_remainder = dividend as captured, o_div_zero=1. This is written on the IDLE->DONE transition. It applies in both modes.
- Signed overflow (most-negative / -1): the quotient wraps to the most-negative value, the remainder is 0, and no flag is raised. This falls out of the magnitude path with no special case.
- DONE (1 cycle): o_done=1, then go to IDLE.
- Latency, with N = the cycle in which i_start is sampled high in IDLE:
  - Normal division: o_done=1 in cycle N+WIDTH+2 (N+18 at default).
  - Divide-by-zero: o_done=1 in cycle N+1.
- Holding: o_quotient, o_remainder and o_div_zero hold their values through IDLE until the next accepted start. o_div_zero is cleared on an accepted start with a nonzero divisor.
- i_start outside IDLE (CALC/FIX/DONE) is ignored. Operand changes during an operation have no effect.
- i_rst during any state: IDLE on the next edge, all outputs 0, no o_done for the aborted operation.

Decomposition:
- Shared constants in arith_defs.vh: state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3) and the default DATA_WIDTH=16. The same header is also used by the ALU opcode decode.
- One natural sub-module: div_step. It is combinational; inputs are the partial remainder, the divisor magnitude and the incoming bit. Outputs are the next remainder and the quotient bit.
- The FSM, counter and sign handling stay in seq_divider.

Test Plan:
- Unsigned: dividend=100, divisor=7, i_signed=0 -> o_done in cycle N+18; Q=14 (0x000E), R=2; o_div_zero=0; o_busy high N+1..N+18.
- Signed: dividend=-100 (0xFF9C), divisor=7, i_signed=1 -> Q=0xFFF2 (-14), R=0xFFFE (-2). Then dividend=100, divisor=-7 -> Q=0xFFF2, R=2.
- Divide-by-zero: dividend=1234, divisor=0 -> o_done in cycle N+1; Q=0xFFFF, R=1234 (0x04D2), o_div_zero=1. The next valid divide clears o_div_zero.
- Edge values:
  - Signed 0x8000 / 0xFFFF -> Q=0x8000, R=0.
  - Unsigned 0xFFFF / 0x0001 -> Q=0xFFFF, R=0.
  - Unsigned 5 / 9 -> Q=0, R=5.
- Handshake: pulse i_start with new operands at N+3 while busy -> ignored; first result unchanged and exactly one o_done. A start in the cycle after DONE is accepted.
- Reset mid-operation: assert i_rst at N+5 for one cycle -> o_busy=0 and all outputs 0 from N+6; no o_done follows. A subsequent 100/7 completes with Q=14, R=2.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic constants: divider state encoding and default datapath width.
// Kept bit-compatible with the encodings the ALU opcode decode expects.
package seq_divider_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider is in CALC.
module seq_divider_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             in_bit,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);

    // Compare at WIDTH+2 bits so the shifted-out top bit is never lost.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvs_ext;

    assign shifted = {rem, in_bit};
    assign dvs_ext = {2'b00, divisor};

    always_comb begin
        q_bit    = 1'b0;
        next_rem = shifted[WIDTH:0];
        if (shifted >= dvs_ext) begin
            q_bit    = 1'b1;
            next_rem = shifted[WIDTH:0] - {1'b0, divisor};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, unsigned or two's-complement signed, one quotient bit per clock.
// Latency: o_done WIDTH+2 cycles after an accepted start, 1 cycle when the divisor is zero.
// Backpressure: i_start is accepted only in IDLE; starts while busy are dropped silently.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd_sh;
    logic [WIDTH-1:0] dvs_mag_q;
    logic             sign_q;
    logic             sign_r;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   next_rem;
    logic             q_bit;

    // Magnitude of the most-negative value is itself read as unsigned, so
    // most-negative / -1 wraps back to most-negative with no special case.
    assign dvd_neg = i_signed & i_dividend[WIDTH-1];
    assign dvs_neg = i_signed & i_divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign dvs_mag = dvs_neg ? (~i_divisor + 1'b1) : i_divisor;

    seq_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .divisor  (dvs_mag_q),
        .in_bit   (dvd_sh[WIDTH-1]),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dvd_sh      <= '0;
            dvs_mag_q   <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_div_zero  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sign_q <= dvd_neg ^ dvs_neg;
                        sign_r <= dvd_neg;
                        o_busy <= 1'b1;
                        if (i_divisor == '0) begin
                            o_quotient  <= '1;
                            o_remainder <= i_dividend;
                            o_div_zero  <= 1'b1;
                            o_done      <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_sh     <= dvd_mag;
                            dvs_mag_q  <= dvs_mag;
                            rem        <= '0;
                            cnt        <= CNT_LAST;
                            o_div_zero <= 1'b0;
                            state      <= CALC;
                        end
                    end
                end
                CALC: begin
                    // dvd_sh drains dividend bits from the top and fills with quotient bits.
                    rem    <= next_rem;
                    dvd_sh <= {dvd_sh[WIDTH-2:0], q_bit};
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    o_quotient  <= sign_q ? (~dvd_sh + 1'b1) : dvd_sh;
                    o_remainder <= sign_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
                    o_done      <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider, checked against an arithmetic model.
module tb_seq_divider;

    localparam int W = 16;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic         i_signed;
    logic [W-1:0] i_dividend;
    logic [W-1:0] i_divisor;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_busy;
    logic         o_done;
    logic         o_div_zero;

    int vectors;
    int miscompares;

    seq_divider #(.WIDTH(W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_signed    (i_signed),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_div_zero  (o_div_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: plain integer division (truncating toward zero) on 32-bit ints.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output int lat);
        int sa;
        int sb;
        int iq;
        int ir;
        if (b == 0) begin
            q = '1;
            r = a;
            dz = 1'b1;
            lat = 1;
        end else begin
            if (s) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
            end else begin
                sa = int'(a);
                sb = int'(b);
            end
            iq = sa / sb;
            ir = sa % sb;
            q = iq[W-1:0];
            r = ir[W-1:0];
            dz = 1'b0;
            lat = W + 2;
        end
    endfunction

    // Starts one operation from IDLE (called just after a rising edge) and waits for o_done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int lat, output int busy_bad);
        i_dividend = a;
        i_divisor  = b;
        i_signed   = s;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start    = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
        i_signed   = 1'($urandom);
        lat = -1;
        busy_bad = 0;
        q = 'x;
        r = 'x;
        dz = 1'bx;
        for (int k = 1; k <= 100; k++) begin
            @(negedge i_clk);
            if (o_busy !== 1'b1) busy_bad++;
            if (o_done === 1'b1) begin
                lat = k;
                q = o_quotient;
                r = o_remainder;
                dz = o_div_zero;
                break;
            end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_signed = 1'b0;
        i_dividend = '0;
        i_divisor = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        vectors += 5;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", o_busy); end
        if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", o_done); end
        if (o_div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz got %0b want 0", o_div_zero); end
        if (o_quotient !== '0) begin miscompares++; $display("FAIL reset_q got %h want 0", o_quotient); end
        if (o_remainder !== '0) begin miscompares++; $display("FAIL reset_r got %h want 0", o_remainder); end
        @(posedge i_clk); #1;
    endtask

    // Directed table: test-plan values including divide-by-zero and edge operands.
    task automatic test_directed;
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         ts [8];
        logic [W-1:0] wq [8];
        logic [W-1:0] wr [8];
        logic         wd [8];
        int           wl [8];
        logic [W-1:0] q, r;
        logic dz;
        int lat, bb;
        ta = '{16'd100, 16'hFF9C, 16'd100, 16'd1234, 16'h8000, 16'hFFFF, 16'd5, 16'd100};
        tb = '{16'd7,   16'd7,    16'hFFF9, 16'd0,   16'hFFFF, 16'h0001, 16'd9, 16'd7};
        ts = '{1'b0,    1'b1,     1'b1,     1'b0,    1'b1,     1'b0,     1'b0,  1'b0};
        wq = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h000E};
        wr = '{16'h0002, 16'hFFFE, 16'h0002, 16'h04D2, 16'h0000, 16'h0000, 16'h0005, 16'h0002};
        wd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        wl = '{18, 18, 18, 1, 18, 18, 18, 18};
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], ts[i], q, r, dz, lat, bb);
            vectors += 5;
            if (lat !== wl[i]) begin miscompares++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, wl[i]); end
            if (q !== wq[i]) begin miscompares++; $display("FAIL dir%0d_q got %h want %h", i, q, wq[i]); end
            if (r !== wr[i]) begin miscompares++; $display("FAIL dir%0d_r got %h want %h", i, r, wr[i]); end
            if (dz !== wd[i]) begin miscompares++; $display("FAIL dir%0d_dz got %0b want %0b", i, dz, wd[i]); end
            if (bb !== 0) begin miscompares++; $display("FAIL dir%0d_busy low in %0d cycles want 0", i, bb); end
            @(negedge i_clk);
            vectors += 4;
            if (o_done !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_pulse got %0b want 0", i, o_done); end
            if (o_busy !== 1'b0) begin miscompares++; $display("FAIL dir%0d_idle_busy got %0b want 0", i, o_busy); end
            if (o_quotient !== wq[i]) begin miscompares++; $display("FAIL dir%0d_hold_q got %h want %h", i, o_quotient, wq[i]); end
            if (o_div_zero !== wd[i]) begin miscompares++; $display("FAIL dir%0d_hold_dz got %0b want %0b", i, o_div_zero, wd[i]); end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_handshake;
        int lat;
        int extra;
        i_dividend = 16'd100;
        i_divisor  = 16'd7;
        i_signed   = 1'b0;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_dividend = 16'd5;
        i_divisor  = 16'd9;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat = -1;
        for (int k = 4; k <= 100; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin lat = k; break; end
        end
        vectors += 3;
        if (lat !== 18) begin miscompares++; $display("FAIL hs_latency got %0d want 18", lat); end
        if (o_quotient !== 16'd14) begin miscompares++; $display("FAIL hs_q got %h want 000e", o_quotient); end
        if (o_remainder !== 16'd2) begin miscompares++; $display("FAIL hs_r got %h want 0002", o_remainder); end
        extra = 0;
        repeat (25) begin
            @(negedge i_clk);
            if (o_done === 1'b1) extra++;
        end
        vectors += 1;
        if (extra !== 0) begin miscompares++; $display("FAIL hs_extra_done got %0d want 0", extra); end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [W-1:0] q, r;
        logic dz;
        int lat, bb;
        i_dividend = 16'd1000;
        i_divisor  = 16'd3;
        i_signed   = 1'b0;
        i_start    = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        vectors += 5;
        if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %0b want 0", o_busy); end
        if (o_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %0b want 0", o_done); end
        if (o_quotient !== '0) begin miscompares++; $display("FAIL rstmid_q got %h want 0", o_quotient); end
        if (o_remainder !== '0) begin miscompares++; $display("FAIL rstmid_r got %h want 0", o_remainder); end
        if (o_div_zero !== 1'b0) begin miscompares++; $display("FAIL rstmid_dz got %0b want 0", o_div_zero); end
        seen = 0;
        repeat (25) begin
            @(negedge i_clk);
            if (o_done === 1'b1 || o_busy === 1'b1) seen++;
        end
        vectors += 1;
        if (seen !== 0) begin miscompares++; $display("FAIL rstmid_ghost_done got %0d want 0", seen); end
        @(posedge i_clk); #1;
        run_op(16'd100, 16'd7, 1'b0, q, r, dz, lat, bb);
        vectors += 3;
        if (lat !== 18) begin miscompares++; $display("FAIL rstmid_after_lat got %0d want 18", lat); end
        if (q !== 16'd14) begin miscompares++; $display("FAIL rstmid_after_q got %h want 000e", q); end
        if (r !== 16'd2) begin miscompares++; $display("FAIL rstmid_after_r got %h want 0002", r); end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, q, r, eq, er;
        logic s, dz, edz;
        int lat, elat, bb;
        for (int i = 0; i < 150; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = '1;
                2: b = W'($urandom_range(1, 15));
                3: begin a = 16'h8000; b = W'($urandom); end
                default: b = W'($urandom);
            endcase
            s = 1'($urandom);
            model(a, b, s, eq, er, edz, elat);
            run_op(a, b, s, q, r, dz, lat, bb);
            vectors += 5;
            if (lat !== elat) begin miscompares++; $display("FAIL rnd_latency a=%h b=%h s=%0b got %0d want %0d", a, b, s, lat, elat); end
            if (q !== eq) begin miscompares++; $display("FAIL rnd_q a=%h b=%h s=%0b got %h want %h", a, b, s, q, eq); end
            if (r !== er) begin miscompares++; $display("FAIL rnd_r a=%h b=%h s=%0b got %h want %h", a, b, s, r, er); end
            if (dz !== edz) begin miscompares++; $display("FAIL rnd_dz a=%h b=%h got %0b want %0b", a, b, dz, edz); end
            if (bb !== 0) begin miscompares++; $display("FAIL rnd_busy low in %0d cycles want 0", bb); end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
